// File: rtl/csr_file.sv
// Machine-mode CSR file: Zicsr read/modify/write with WARL masking, trap/MRET
// state updates, 64-bit counters with inhibit, trap vector and interrupt request.
module csr_file #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] HART_ID     = {XLEN{1'b0}},
  parameter logic [XLEN-1:0] MISA_VALUE  = XLEN'(32'h4000_0100),
  parameter logic [XLEN-1:0] MTVEC_RESET = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            csr_valid,
  input  logic [11:0]     csr_addr,
  input  logic [2:0]      csr_op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            rs1_is_x0,
  input  logic [4:0]      zimm,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            trap_valid,
  input  logic            trap_is_intr,
  input  logic [4:0]      trap_code,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret_valid,
  input  logic            instret_inc,
  input  logic            irq_ext,
  input  logic            irq_timer,
  input  logic            irq_sw,
  output logic [XLEN-1:0] trap_vector,
  output logic [XLEN-1:0] mepc_out,
  output logic            irq_pending
);

  localparam logic [11:0] ADDR_MSTATUS       = 12'h300;
  localparam logic [11:0] ADDR_MISA          = 12'h301;
  localparam logic [11:0] ADDR_MIE           = 12'h304;
  localparam logic [11:0] ADDR_MTVEC         = 12'h305;
  localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] ADDR_MSCRATCH      = 12'h340;
  localparam logic [11:0] ADDR_MEPC          = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE        = 12'h342;
  localparam logic [11:0] ADDR_MTVAL         = 12'h343;
  localparam logic [11:0] ADDR_MIP           = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE        = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET      = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] ADDR_MVENDORID     = 12'hF11;
  localparam logic [11:0] ADDR_MARCHID       = 12'hF12;
  localparam logic [11:0] ADDR_MIMPID        = 12'hF13;
  localparam logic [11:0] ADDR_MHARTID       = 12'hF14;

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {
    OP_RW,
    OP_RS,
    OP_RC
  } op_kind_t;

  logic              mstatus_mie_r;
  logic              mstatus_mpie_r;
  logic              meie_r;
  logic              mtie_r;
  logic              msie_r;
  logic              meip_r;
  logic              mtip_r;
  logic              msip_r;
  logic [XLEN-1:0]   mcause_r;
  logic [XLEN-1:0]   mtval_r;
  logic [XLEN-1:0]   mepc_r;
  logic [XLEN-1:0]   mscratch_r;
  logic [XLEN-3:0]   mtvec_base_r;
  logic              mtvec_mode_r;
  logic              cy_inh_r;
  logic              ir_inh_r;
  logic [63:0]       mcycle_r;
  logic [63:0]       minstret_r;
  logic              irq_pending_r;

  logic [XLEN-1:0]   mstatus_val_s;
  logic [XLEN-1:0]   mie_val_s;
  logic [XLEN-1:0]   mip_val_s;
  logic [XLEN-1:0]   mtvec_val_s;
  logic [XLEN-1:0]   mcountinhibit_val_s;
  logic [XLEN-1:0]   rdata_s;
  logic              addr_known_s;
  logic              op_known_s;
  logic              we_s;
  op_kind_t          op_kind_s;
  logic [XLEN-1:0]   src_s;
  logic [XLEN-1:0]   wdata_s;
  logic              illegal_s;
  logic              do_write_s;

  logic wr_mstatus_s, wr_mie_s, wr_mtvec_s, wr_mcountinhibit_s, wr_mscratch_s;
  logic wr_mepc_s, wr_mcause_s, wr_mtval_s;
  logic wr_mcycle_s, wr_mcycleh_s, wr_minstret_s, wr_minstreth_s;

  // Architectural read views of the sparsely implemented registers.
  always_comb begin
    mstatus_val_s            = {XLEN{1'b0}};
    mstatus_val_s[12:11]     = 2'b11;
    mstatus_val_s[7]         = mstatus_mpie_r;
    mstatus_val_s[3]         = mstatus_mie_r;
    mie_val_s                = {XLEN{1'b0}};
    mie_val_s[11]            = meie_r;
    mie_val_s[7]             = mtie_r;
    mie_val_s[3]             = msie_r;
    mip_val_s                = {XLEN{1'b0}};
    mip_val_s[11]            = meip_r;
    mip_val_s[7]             = mtip_r;
    mip_val_s[3]             = msip_r;
    mtvec_val_s              = {mtvec_base_r, 1'b0, mtvec_mode_r};
    mcountinhibit_val_s      = {XLEN{1'b0}};
    mcountinhibit_val_s[2]   = ir_inh_r;
    mcountinhibit_val_s[0]   = cy_inh_r;
  end

  // Address decode and read mux; h halves only exist for a 32-bit register width.
  always_comb begin
    rdata_s      = {XLEN{1'b0}};
    addr_known_s = 1'b1;
    case (csr_addr) inside
      ADDR_MSTATUS:       rdata_s = mstatus_val_s;
      ADDR_MISA:          rdata_s = MISA_VALUE;
      ADDR_MIE:           rdata_s = mie_val_s;
      ADDR_MTVEC:         rdata_s = mtvec_val_s;
      ADDR_MCOUNTINHIBIT: rdata_s = mcountinhibit_val_s;
      ADDR_MSCRATCH:      rdata_s = mscratch_r;
      ADDR_MEPC:          rdata_s = mepc_r;
      ADDR_MCAUSE:        rdata_s = mcause_r;
      ADDR_MTVAL:         rdata_s = mtval_r;
      ADDR_MIP:           rdata_s = mip_val_s;
      ADDR_MCYCLE:        rdata_s = mcycle_r[XLEN-1:0];
      ADDR_MINSTRET:      rdata_s = minstret_r[XLEN-1:0];
      ADDR_MHARTID:       rdata_s = HART_ID;
      ADDR_MCYCLEH: begin
        if (XLEN == 32) begin
          rdata_s = XLEN'(mcycle_r[63:32]);
        end else begin
          addr_known_s = 1'b0;
        end
      end
      ADDR_MINSTRETH: begin
        if (XLEN == 32) begin
          rdata_s = XLEN'(minstret_r[63:32]);
        end else begin
          addr_known_s = 1'b0;
        end
      end
      ADDR_MVENDORID, ADDR_MARCHID, ADDR_MIMPID,
      [12'hB03:12'hB1F], [12'h323:12'h33F]: rdata_s = {XLEN{1'b0}};
      [12'hB83:12'hB9F]:  addr_known_s = (XLEN == 32);
      default:            addr_known_s = 1'b0;
    endcase
  end

  // Op decode: write-enable, source operand and modified value.
  always_comb begin
    op_known_s = 1'b1;
    we_s       = 1'b0;
    op_kind_s  = OP_RW;
    case (csr_op)
      3'b001, 3'b101: begin
        we_s      = 1'b1;
        op_kind_s = OP_RW;
      end
      3'b010: begin
        we_s      = !rs1_is_x0;
        op_kind_s = OP_RS;
      end
      3'b011: begin
        we_s      = !rs1_is_x0;
        op_kind_s = OP_RC;
      end
      3'b110: begin
        we_s      = (zimm != 5'd0);
        op_kind_s = OP_RS;
      end
      3'b111: begin
        we_s      = (zimm != 5'd0);
        op_kind_s = OP_RC;
      end
      default: op_known_s = 1'b0;
    endcase
    if (csr_op[2]) begin
      src_s = {{(XLEN-5){1'b0}}, zimm};
    end else begin
      src_s = rs1_data;
    end
    case (op_kind_s)
      OP_RS:   wdata_s = rdata_s | src_s;
      OP_RC:   wdata_s = rdata_s & ~src_s;
      default: wdata_s = src_s;
    endcase
  end

  // Illegal detection; a trap or MRET in the same cycle drops the CSR write.
  always_comb begin
    if (csr_valid) begin
      illegal_s = !addr_known_s || !op_known_s || (we_s && (csr_addr[11:10] == 2'b11));
    end else begin
      illegal_s = 1'b0;
    end
    do_write_s = csr_valid && !illegal_s && we_s && !trap_valid && !mret_valid;
  end

  assign wr_mstatus_s       = do_write_s && (csr_addr == ADDR_MSTATUS);
  assign wr_mie_s           = do_write_s && (csr_addr == ADDR_MIE);
  assign wr_mtvec_s         = do_write_s && (csr_addr == ADDR_MTVEC);
  assign wr_mcountinhibit_s = do_write_s && (csr_addr == ADDR_MCOUNTINHIBIT);
  assign wr_mscratch_s      = do_write_s && (csr_addr == ADDR_MSCRATCH);
  assign wr_mepc_s          = do_write_s && (csr_addr == ADDR_MEPC);
  assign wr_mcause_s        = do_write_s && (csr_addr == ADDR_MCAUSE);
  assign wr_mtval_s         = do_write_s && (csr_addr == ADDR_MTVAL);
  assign wr_mcycle_s        = do_write_s && (csr_addr == ADDR_MCYCLE);
  assign wr_mcycleh_s       = do_write_s && (csr_addr == ADDR_MCYCLEH);
  assign wr_minstret_s      = do_write_s && (csr_addr == ADDR_MINSTRET);
  assign wr_minstreth_s     = do_write_s && (csr_addr == ADDR_MINSTRETH);

  // Machine state: trap entry beats MRET, which beats an explicit CSR write.
  always_ff @(posedge clk) begin
    if (reset) begin
      mstatus_mie_r  <= 1'b0;
      mstatus_mpie_r <= 1'b0;
      meie_r         <= 1'b0;
      mtie_r         <= 1'b0;
      msie_r         <= 1'b0;
      meip_r         <= 1'b0;
      mtip_r         <= 1'b0;
      msip_r         <= 1'b0;
      mcause_r       <= {XLEN{1'b0}};
      mtval_r        <= {XLEN{1'b0}};
      mepc_r         <= {XLEN{1'b0}};
      mscratch_r     <= {XLEN{1'b0}};
      mtvec_base_r   <= MTVEC_RESET[XLEN-1:2];
      mtvec_mode_r   <= MTVEC_RESET[0];
      cy_inh_r       <= 1'b0;
      ir_inh_r       <= 1'b0;
      irq_pending_r  <= 1'b0;
    end else begin
      meip_r        <= irq_ext;
      mtip_r        <= irq_timer;
      msip_r        <= irq_sw;
      irq_pending_r <= mstatus_mie_r &&
                       ((meip_r && meie_r) || (mtip_r && mtie_r) || (msip_r && msie_r));
      if (trap_valid) begin
        mepc_r         <= trap_pc & ALIGN_MASK;
        mcause_r       <= {trap_is_intr, {(XLEN-6){1'b0}}, trap_code};
        mtval_r        <= trap_tval;
        mstatus_mpie_r <= mstatus_mie_r;
        mstatus_mie_r  <= 1'b0;
      end else if (mret_valid) begin
        mstatus_mie_r  <= mstatus_mpie_r;
        mstatus_mpie_r <= 1'b1;
      end else begin
        if (wr_mstatus_s) begin
          mstatus_mie_r  <= wdata_s[3];
          mstatus_mpie_r <= wdata_s[7];
        end
        if (wr_mie_s) begin
          meie_r <= wdata_s[11];
          mtie_r <= wdata_s[7];
          msie_r <= wdata_s[3];
        end
        if (wr_mtvec_s) begin
          mtvec_base_r <= wdata_s[XLEN-1:2];
          if (wdata_s[1:0] == 2'b00) begin
            mtvec_mode_r <= 1'b0;
          end else if (wdata_s[1:0] == 2'b01) begin
            mtvec_mode_r <= 1'b1;
          end
        end
        if (wr_mcountinhibit_s) begin
          cy_inh_r <= wdata_s[0];
          ir_inh_r <= wdata_s[2];
        end
        if (wr_mscratch_s) mscratch_r <= wdata_s;
        if (wr_mepc_s)     mepc_r     <= wdata_s & ALIGN_MASK;
        if (wr_mcause_s)   mcause_r   <= wdata_s;
        if (wr_mtval_s)    mtval_r    <= wdata_s;
      end
    end
  end

  // Cycle counter: an explicit write to either half wins and holds the other half.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcycle_r <= 64'd0;
    end else if (wr_mcycle_s) begin
      if (XLEN == 32) begin
        mcycle_r[31:0] <= wdata_s[31:0];
      end else begin
        mcycle_r <= 64'(wdata_s);
      end
    end else if (wr_mcycleh_s) begin
      mcycle_r[63:32] <= wdata_s[31:0];
    end else if (!cy_inh_r) begin
      mcycle_r <= mcycle_r + 64'd1;
    end
  end

  // Retired-instruction counter, same write-over-increment rule.
  always_ff @(posedge clk) begin
    if (reset) begin
      minstret_r <= 64'd0;
    end else if (wr_minstret_s) begin
      if (XLEN == 32) begin
        minstret_r[31:0] <= wdata_s[31:0];
      end else begin
        minstret_r <= 64'(wdata_s);
      end
    end else if (wr_minstreth_s) begin
      minstret_r[63:32] <= wdata_s[31:0];
    end else if (instret_inc && !ir_inh_r) begin
      minstret_r <= minstret_r + 64'd1;
    end
  end

  // Vectored mode only offsets interrupts; exceptions always go to BASE.
  always_comb begin
    if (mtvec_mode_r && trap_is_intr) begin
      trap_vector = {mtvec_base_r, 2'b00} + {{(XLEN-7){1'b0}}, trap_code, 2'b00};
    end else begin
      trap_vector = {mtvec_base_r, 2'b00};
    end
  end

  assign csr_rdata   = rdata_s;
  assign csr_illegal = illegal_s;
  assign mepc_out    = mepc_r;
  assign irq_pending = irq_pending_r;

endmodule

// File: tb/tb_csr_file.sv
// Directed scoreboard bench for csr_file: the driver queues expected values per
// cycle, a negedge monitor pops and compares them against the DUT outputs.
module tb_csr_file;
  localparam int          XLEN = 32;
  localparam logic [31:0] HART = 32'h0000_0005;
  localparam logic [31:0] MTVR = 32'h0000_1000;

  localparam logic [2:0] RW = 3'b001, RS = 3'b010, RC = 3'b011;
  localparam logic [2:0] RWI = 3'b101, RSI = 3'b110;

  localparam logic [11:0] A_MSTATUS = 12'h300, A_MIE = 12'h304, A_MTVEC = 12'h305;
  localparam logic [11:0] A_MCI = 12'h320, A_MSCRATCH = 12'h340, A_MEPC = 12'h341;
  localparam logic [11:0] A_MCAUSE = 12'h342, A_MTVAL = 12'h343, A_MIP = 12'h344;
  localparam logic [11:0] A_MCYCLE = 12'hB00, A_MINSTRET = 12'hB02, A_MCYCLEH = 12'hB80;
  localparam logic [11:0] A_MVENDORID = 12'hF11, A_MHARTID = 12'hF14;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            csr_valid = 1'b0;
  logic [11:0]     csr_addr = 12'h000;
  logic [2:0]      csr_op = 3'b000;
  logic [XLEN-1:0] rs1_data = 32'h0;
  logic            rs1_is_x0 = 1'b1;
  logic [4:0]      zimm = 5'd0;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;
  logic            trap_valid = 1'b0;
  logic            trap_is_intr = 1'b0;
  logic [4:0]      trap_code = 5'd0;
  logic [XLEN-1:0] trap_pc = 32'h0;
  logic [XLEN-1:0] trap_tval = 32'h0;
  logic            mret_valid = 1'b0;
  logic            instret_inc = 1'b0;
  logic            irq_ext = 1'b0, irq_timer = 1'b0, irq_sw = 1'b0;
  logic [XLEN-1:0] trap_vector;
  logic [XLEN-1:0] mepc_out;
  logic            irq_pending;

  csr_file #(.XLEN(XLEN), .HART_ID(HART), .MISA_VALUE(32'h4000_0100), .MTVEC_RESET(MTVR)) dut (
    .clk(clk), .reset(reset), .csr_valid(csr_valid), .csr_addr(csr_addr), .csr_op(csr_op),
    .rs1_data(rs1_data), .rs1_is_x0(rs1_is_x0), .zimm(zimm), .csr_rdata(csr_rdata),
    .csr_illegal(csr_illegal), .trap_valid(trap_valid), .trap_is_intr(trap_is_intr),
    .trap_code(trap_code), .trap_pc(trap_pc), .trap_tval(trap_tval), .mret_valid(mret_valid),
    .instret_inc(instret_inc), .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_sw(irq_sw),
    .trap_vector(trap_vector), .mepc_out(mepc_out), .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  typedef enum logic [2:0] {K_RDATA, K_ILL, K_TVEC, K_MEPC, K_IRQ} kind_t;
  typedef struct {
    kind_t       kind;
    logic [31:0] value;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] mon_act;
  int          checks = 0;
  int          passed = 0;

  // Monitor: everything queued during a cycle is compared at that cycle's negedge.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        case (mon_e.kind)
          K_RDATA: mon_act = csr_rdata;
          K_ILL:   mon_act = {31'd0, csr_illegal};
          K_TVEC:  mon_act = trap_vector;
          K_MEPC:  mon_act = mepc_out;
          default: mon_act = {31'd0, irq_pending};
        endcase
        checks++;
        if (mon_act === mon_e.value) begin
          passed++;
        end else begin
          $display("FAIL %s: got %h expected %h", mon_e.name, mon_act, mon_e.value);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    csr_valid  = 1'b0;
    trap_valid = 1'b0;
    mret_valid = 1'b0;
    csr_op     = 3'b000;
    rs1_is_x0  = 1'b1;
    rs1_data   = 32'h0;
    zimm       = 5'd0;
    csr_addr   = 12'h000;
  endtask

  task automatic expect_val(input kind_t k, input logic [31:0] v, input string n);
    exp_t e;
    e.kind  = k;
    e.value = v;
    e.name  = n;
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [11:0] a, input logic [2:0] op, input logic [31:0] d);
    csr_valid = 1'b1;
    csr_addr  = a;
    csr_op    = op;
    rs1_data  = d;
    rs1_is_x0 = 1'b0;
  endtask

  task automatic wri(input logic [11:0] a, input logic [2:0] op, input logic [4:0] z);
    csr_valid = 1'b1;
    csr_addr  = a;
    csr_op    = op;
    zimm      = z;
  endtask

  // CSRRS with x0: pure read, must be legal.
  task automatic rd(input logic [11:0] a, input logic [31:0] v, input string n);
    csr_valid = 1'b1;
    csr_addr  = a;
    csr_op    = RS;
    rs1_is_x0 = 1'b1;
    expect_val(K_RDATA, v, n);
    expect_val(K_ILL, 32'd0, {n, "_legal"});
  endtask

  task automatic trap(input logic intr, input logic [4:0] code, input logic [31:0] pc,
                      input logic [31:0] tval);
    trap_valid   = 1'b1;
    trap_is_intr = intr;
    trap_code    = code;
    trap_pc      = pc;
    trap_tval    = tval;
  endtask

  initial begin
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    rd(A_MSTATUS, 32'h0000_1800, "mstatus_reset");
    expect_val(K_IRQ, 32'd0, "irq_reset");
    expect_val(K_MEPC, 32'd0, "mepc_out_reset");
    next_cycle(); rd(A_MTVEC, 32'h0000_1000, "mtvec_reset");
    next_cycle(); wr(A_MTVEC, RW, 32'h8000_0003);
    next_cycle(); rd(A_MTVEC, 32'h8000_0000, "mtvec_mode_kept");
    next_cycle(); wri(A_MTVEC, RWI, 5'd1);
    next_cycle(); rd(A_MTVEC, 32'h0000_0001, "mtvec_rwi");
    next_cycle(); wr(A_MTVEC, RW, 32'h0000_0101);
    next_cycle(); wr(A_MIE, RS, 32'h0000_0080);
    next_cycle(); wri(A_MSTATUS, RSI, 5'd8); irq_timer = 1'b1;
    next_cycle(); rd(A_MIP, 32'h0000_0080, "mip_mtip"); expect_val(K_IRQ, 32'd0, "irq_latency");
    next_cycle(); rd(A_MSTATUS, 32'h0000_1808, "mstatus_mie"); expect_val(K_IRQ, 32'd1, "irq_pending");
    next_cycle(); trap(1'b1, 5'd7, 32'h0000_0206, 32'h0000_1234);
    expect_val(K_TVEC, 32'h0000_011C, "tvec_vectored");
    next_cycle(); rd(A_MEPC, 32'h0000_0204, "mepc_trap"); expect_val(K_MEPC, 32'h0000_0204, "mepc_out_trap");
    next_cycle(); rd(A_MCAUSE, 32'h8000_0007, "mcause_intr");
    next_cycle(); rd(A_MTVAL, 32'h0000_1234, "mtval_trap");
    next_cycle(); rd(A_MSTATUS, 32'h0000_1880, "mstatus_trap"); expect_val(K_IRQ, 32'd0, "irq_masked");
    next_cycle(); mret_valid = 1'b1;
    next_cycle(); rd(A_MSTATUS, 32'h0000_1888, "mstatus_mret");
    next_cycle(); wr(A_MSCRATCH, RW, 32'h0000_00AA);
    next_cycle(); trap(1'b0, 5'd2, 32'h0000_0301, 32'h0000_0BAD); wr(A_MSCRATCH, RW, 32'h0000_0055);
    expect_val(K_RDATA, 32'h0000_00AA, "rdata_during_trap");
    expect_val(K_TVEC, 32'h0000_0100, "tvec_exception");
    next_cycle(); rd(A_MSCRATCH, 32'h0000_00AA, "mscratch_dropped");
    next_cycle(); rd(A_MCAUSE, 32'h0000_0002, "mcause_exc");
    next_cycle(); rd(A_MEPC, 32'h0000_0300, "mepc_exc");
    next_cycle(); rd(A_MSTATUS, 32'h0000_1880, "mstatus_exc");
    // Illegal accesses and read-zero space.
    next_cycle(); wr(12'h7C0, RW, 32'h1); expect_val(K_ILL, 32'd1, "illegal_addr");
    next_cycle(); wr(A_MHARTID, RW, 32'h1); expect_val(K_ILL, 32'd1, "illegal_ro_write");
    next_cycle(); rd(A_MHARTID, HART, "mhartid");
    next_cycle(); wr(A_MSCRATCH, 3'b100, 32'hFF); expect_val(K_ILL, 32'd1, "illegal_op");
    next_cycle(); rd(A_MSCRATCH, 32'h0000_00AA, "mscratch_after_illegal");
    next_cycle(); rd(A_MVENDORID, 32'h0, "mvendorid");
    next_cycle(); wr(12'hB03, RW, 32'hFF); expect_val(K_ILL, 32'd0, "hpm_write_legal");
    next_cycle(); rd(12'hB03, 32'h0, "hpm_reads_zero");
    next_cycle(); wr(A_MSCRATCH, RC, 32'h0000_000F);
    next_cycle(); wri(A_MSCRATCH, RSI, 5'd0); expect_val(K_RDATA, 32'h0000_00A0, "mscratch_rc");
    next_cycle(); rd(A_MSCRATCH, 32'h0000_00A0, "mscratch_rsi_zero");
    next_cycle(); wr(A_MEPC, RW, 32'h0000_1237);
    next_cycle(); rd(A_MEPC, 32'h0000_1234, "mepc_align");
    // Counters: write wins over increment, 64-bit wrap, inhibit.
    next_cycle(); instret_inc = 1'b1; wr(A_MINSTRET, RW, 32'd10);
    next_cycle(); rd(A_MINSTRET, 32'd10, "minstret_write_wins");
    next_cycle(); instret_inc = 1'b0; rd(A_MINSTRET, 32'd11, "minstret_inc");
    next_cycle(); wr(A_MCYCLEH, RW, 32'hFFFF_FFFF);
    next_cycle(); wr(A_MCYCLE, RW, 32'hFFFF_FFFF);
    next_cycle(); rd(A_MCYCLEH, 32'hFFFF_FFFF, "mcycleh_max");
    next_cycle(); rd(A_MCYCLE, 32'h0, "mcycle_wrap");
    next_cycle(); rd(A_MCYCLEH, 32'h0, "mcycleh_wrap");
    next_cycle(); wri(A_MCI, RWI, 5'h1F);
    next_cycle(); instret_inc = 1'b1; rd(A_MCI, 32'd5, "mcountinhibit_warl");
    next_cycle(); rd(A_MCYCLE, 32'd3, "mcycle_frozen_a");
    next_cycle(); rd(A_MCYCLE, 32'd3, "mcycle_frozen_b");
    next_cycle(); rd(A_MINSTRET, 32'd11, "minstret_frozen_a");
    next_cycle(); rd(A_MINSTRET, 32'd11, "minstret_frozen_b");
    // Reset in the middle of activity.
    next_cycle(); instret_inc = 1'b0; irq_timer = 1'b0; reset = 1'b1; wr(A_MSCRATCH, RW, 32'h77);
    next_cycle(); reset = 1'b0; rd(A_MCYCLE, 32'h0, "mcycle_after_reset");
    next_cycle(); rd(A_MSCRATCH, 32'h0, "mscratch_after_reset");
    next_cycle(); rd(A_MTVEC, MTVR, "mtvec_after_reset");
    next_cycle(); rd(A_MSTATUS, 32'h0000_1800, "mstatus_after_reset");
    expect_val(K_IRQ, 32'd0, "irq_after_reset");
    expect_val(K_MEPC, 32'd0, "mepc_out_after_reset");
    next_cycle(); rd(A_MCI, 32'h0, "mcountinhibit_after_reset");
    next_cycle(); rd(A_MIE, 32'h0, "mie_after_reset");
    next_cycle(); rd(A_MINSTRET, 32'h0, "minstret_after_reset");
    next_cycle();
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      passed++;
    end else begin
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
